// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer core.
// A game runs ROUNDS trials. Each trial waits a random delay taken from an
// internal LFSR, lights the lamp, and measures the reaction in ms as packed
// BCD. A false start in any round shows all 9s for that round. The best
// (minimum) time of the game is kept until the next game starts.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_RAND | random pre-stimulus delay running, lamp off
// TIMING    | lamp on, counting ms until react or all-9s timeout
// FALSE     | react came before the lamp, show all 9s for SHOW_MS
// SHOW      | show the round time for SHOW_MS, then next round or DONE
// DONE      | game over, results held until the next start
module reaction_timer_multi #(
    parameter int                    DIGITS       = 4,
    parameter int                    TICK_DIV     = 50000,
    parameter int                    LFSR_WIDTH   = 12,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = 12'hE08,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = '1,
    parameter int                    MIN_DELAY_MS = 1000,
    parameter logic [LFSR_WIDTH-1:0] RAND_MASK    = 12'h3FF,
    parameter int                    ROUNDS       = 4,
    parameter int                    SHOW_MS      = 2000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  react,
    output logic                  led,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic [3:0]            round_idx,
    output logic                  false_start,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RAND = 3'd1,
        S_TIMING    = 3'd2,
        S_FALSE     = 3'd3,
        S_SHOW      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};
    localparam logic [4*DIGITS-1:0] ZERO = '0;

    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

    // The ms counter serves both the random delay and the display hold.
    localparam int DELAY_MAX = MIN_DELAY_MS + int'(RAND_MASK);
    localparam int MS_MAX    = (DELAY_MAX > SHOW_MS) ? DELAY_MAX : SHOW_MS;
    localparam int MS_W      = (MS_MAX < 1) ? 1 : $clog2(MS_MAX + 1);
    localparam logic [MS_W-1:0] MS_MIN    = MS_W'(MIN_DELAY_MS);
    localparam logic [MS_W-1:0] MS_SHOW   = MS_W'(SHOW_MS);
    localparam logic [MS_W-1:0] MS_ONE    = MS_W'(1);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t                  state;
    state_t                  state_next;
    logic [LFSR_WIDTH-1:0]   lfsr;
    logic                    lfsr_fb;
    logic [TW-1:0]           tick_cnt;
    logic [MS_W-1:0]         ms_cnt;
    logic                    tick;
    logic                    expire;
    logic                    entering;
    logic                    new_game;
    logic [4*DIGITS-1:0]     time_inc;
    logic [4*DIGITS-1:0]     time_next;
    logic [4*DIGITS-1:0]     best_next;
    logic [3:0]              round_next;
    logic                    led_next;
    logic                    false_start_next;
    logic                    busy_next;
    logic                    done_next;

    // Packed-BCD increment with decimal carry across all digits.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'h9) begin
                    r[4*i +: 4] = 4'h0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'h1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // All-ones is the XNOR lockup word; it only exists as the reset value,
    // so force a zero in to leave it on the first step.
    assign lfsr_fb = (&lfsr) ? 1'b0 : ~(^(lfsr & LFSR_TAPS));

    assign tick     = (tick_cnt == TICK_LAST);
    assign expire   = tick && (ms_cnt <= MS_ONE);
    assign entering = (state_next != state);
    assign new_game = entering && (state_next == S_WAIT_RAND) &&
                      ((state == S_IDLE) || (state == S_DONE));
    assign time_inc = bcd_inc(time_bcd);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; react has priority over delay expiry and tick.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_WAIT_RAND;
            end
            S_WAIT_RAND: begin
                if (react)       state_next = S_FALSE;
                else if (expire) state_next = S_TIMING;
            end
            S_TIMING: begin
                if (react)                          state_next = S_SHOW;
                else if (tick && time_inc == ALL9)  state_next = S_SHOW;
            end
            S_FALSE, S_SHOW: begin
                if (expire) state_next = (round_idx == LAST_ROUND) ? S_DONE : S_WAIT_RAND;
            end
            S_DONE: begin
                if (start) state_next = S_WAIT_RAND;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so outputs register on the entry edge.
    always_comb begin
        led_next         = (state_next == S_TIMING);
        false_start_next = (state_next == S_FALSE);
        busy_next        = (state_next != S_IDLE) && (state_next != S_DONE);
        done_next        = (state_next == S_DONE);
    end

    // Registered state outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            led         <= 1'b0;
            false_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            led         <= led_next;
            false_start <= false_start_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

    // Free-running LFSR, stepping in every state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[LFSR_WIDTH-2:0], lfsr_fb};
        end
    end

    // Tick divider and ms down-counter, both restarted on every state entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
        end else if (entering) begin
            tick_cnt <= '0;
            case (state_next)
                S_WAIT_RAND:     ms_cnt <= MS_MIN + MS_W'(lfsr & RAND_MASK);
                S_FALSE, S_SHOW: ms_cnt <= MS_SHOW;
                default:         ms_cnt <= '0;
            endcase
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick && (ms_cnt != '0)) ms_cnt <= ms_cnt - MS_ONE;
        end
    end

    // Next values for the round time, best time and round index.
    always_comb begin
        time_next  = time_bcd;
        best_next  = best_bcd;
        round_next = round_idx;
        if (new_game) begin
            time_next  = ZERO;
            best_next  = ALL9;
            round_next = 4'd0;
        end else if (entering) begin
            case (state_next)
                S_WAIT_RAND: round_next = round_idx + 4'd1;
                S_TIMING:    time_next  = ZERO;
                S_FALSE:     time_next  = ALL9;
                S_SHOW: begin
                    // Timeout lands on all 9s; a react holds the current count.
                    if (!react) time_next = time_inc;
                    if (time_next < best_bcd) best_next = time_next;
                end
                default: ;
            endcase
        end else if ((state == S_TIMING) && tick) begin
            time_next = time_inc;
        end
    end

    // Result registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            time_bcd  <= ZERO;
            best_bcd  <= ALL9;
            round_idx <= 4'd0;
        end else begin
            time_bcd  <= time_next;
            best_bcd  <= best_next;
            round_idx <= round_next;
        end
    end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Bench for reaction_timer_multi with small timing parameters.
module tb_reaction_timer_multi;

    localparam int          DIGITS   = 2;
    localparam int          TICK_DIV = 4;
    localparam int          LW       = 12;
    localparam logic [11:0] TAPS     = 12'hE08;
    localparam logic [11:0] SEED     = 12'h5A3;
    localparam logic [11:0] MASK     = 12'h003;
    localparam int          MIN_MS   = 3;
    localparam int          ROUNDS   = 2;
    localparam int          SHOW_MS  = 2;
    localparam int          NREC     = 8;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic        led;
    logic [7:0]  time_bcd;
    logic [7:0]  best_bcd;
    logic [3:0]  round_idx;
    logic        false_start;
    logic        busy;
    logic        done;

    reaction_timer_multi #(
        .DIGITS       (DIGITS),
        .TICK_DIV     (TICK_DIV),
        .LFSR_WIDTH   (LW),
        .LFSR_TAPS    (TAPS),
        .LFSR_SEED    (SEED),
        .MIN_DELAY_MS (MIN_MS),
        .RAND_MASK    (MASK),
        .ROUNDS       (ROUNDS),
        .SHOW_MS      (SHOW_MS)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .react       (react),
        .led         (led),
        .time_bcd    (time_bcd),
        .best_bcd    (best_bcd),
        .round_idx   (round_idx),
        .false_start (false_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR: XNOR feedback shifted into bit 0, all-ones escapes to ...110.
    function automatic logic [11:0] lfsr_step(input logic [11:0] x);
        logic fb;
        fb = (&x) ? 1'b0 : ~(^(x & TAPS));
        return {x[10:0], fb};
    endfunction

    logic [11:0] lfsr_m;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) lfsr_m <= SEED;
        else       lfsr_m <= lfsr_step(lfsr_m);
    end

    typedef enum int {K_NORMAL, K_FALSE, K_TIMEOUT, K_SIMUL} kind_t;

    typedef struct {
        kind_t      kind;
        int         react_at;
        bit         start_busy;
        logic [7:0] exp_time;
        logic [7:0] exp_best;
    } rec_t;

    typedef struct {
        logic [7:0] t;
        logic [7:0] b;
        logic       fs;
        logic       l;
    } exp_t;

    rec_t tbl [NREC];
    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   delay_ms = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", name);
            return;
        end
        e = sb_q.pop_front();
        check({name, " time_bcd"},    time_bcd,    e.t);
        check({name, " best_bcd"},    best_bcd,    e.b);
        check({name, " false_start"}, false_start, e.fs);
        check({name, " led"},         led,         e.l);
    endtask

    task automatic start_game();
        delay_ms = MIN_MS + int'(lfsr_m & MASK);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start busy",      busy,      1);
        check("start done",      done,      0);
        check("start round_idx", round_idx, 0);
        check("start best_bcd",  best_bcd,  8'h99);
        check("start time_bcd",  time_bcd,  8'h00);
        check("start led",       led,       0);
    endtask

    task automatic wait_led(input bit pulse_start, input int exp_round);
        int cnt;
        cnt = 0;
        while (!led && cnt < 200) begin
            if (pulse_start && cnt == 0) start = 1'b1;
            step(1);
            start = 1'b0;
            cnt++;
        end
        check("led latency", cnt, delay_ms * TICK_DIV);
        check("timing round_idx", round_idx, exp_round);
        check("timing time_bcd", time_bcd, 8'h00);
    endtask

    task automatic finish_round(input rec_t r, input int ri);
        int fs_cnt;
        fs_cnt = false_start ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (false_start) fs_cnt++;
        end
        check("hold busy", busy, 1);
        delay_ms = MIN_MS + int'(lfsr_m & MASK);
        step(1);
        if (r.kind == K_FALSE || r.kind == K_SIMUL) check("false_start cycles", fs_cnt, 8);
        check("exit false_start", false_start, 0);
        if (ri == ROUNDS - 1) begin
            check("done flag",     done,     1);
            check("done busy",     busy,     0);
            check("done time_bcd", time_bcd, r.exp_time);
            check("done best_bcd", best_bcd, r.exp_best);
        end else begin
            check("next round_idx", round_idx, ri + 1);
            check("next busy",      busy,      1);
            check("next done",      done,      0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{K_NORMAL,  28, 1'b0, 8'h07, 8'h07};
        tbl[1] = '{K_FALSE,    0, 1'b0, 8'h99, 8'h07};
        tbl[2] = '{K_NORMAL,  48, 1'b1, 8'h12, 8'h12};
        tbl[3] = '{K_NORMAL,  20, 1'b0, 8'h05, 8'h05};
        tbl[4] = '{K_NORMAL,  23, 1'b0, 8'h05, 8'h05};
        tbl[5] = '{K_NORMAL,  48, 1'b0, 8'h12, 8'h05};
        tbl[6] = '{K_TIMEOUT,  0, 1'b0, 8'h99, 8'h99};
        tbl[7] = '{K_SIMUL,    0, 1'b0, 8'h99, 8'h99};

        step(2);
        check("reset led",         led,         0);
        check("reset busy",        busy,        0);
        check("reset done",        done,        0);
        check("reset false_start", false_start, 0);
        check("reset time_bcd",    time_bcd,    8'h00);
        check("reset best_bcd",    best_bcd,    8'h99);
        check("reset round_idx",   round_idx,   0);
        Reset = 1'b0;
        step(3);

        react = 1'b1;
        step(1);
        react = 1'b0;
        check("idle react busy",        busy,        0);
        check("idle react false_start", false_start, 0);

        for (int i = 0; i < NREC; i++) begin
            int ri;
            ri = i % ROUNDS;
            if (ri == 0) start_game();
            case (tbl[i].kind)
                K_NORMAL: begin
                    wait_led(tbl[i].start_busy, ri);
                    step(tbl[i].react_at);
                    react = 1'b1;
                    sb_q.push_back('{tbl[i].exp_time, tbl[i].exp_best, 1'b0, 1'b0});
                    step(1);
                    react = 1'b0;
                    sb_check("react round");
                end
                K_FALSE: begin
                    step(2);
                    react = 1'b1;
                    sb_q.push_back('{8'h99, tbl[i].exp_best, 1'b1, 1'b0});
                    step(1);
                    react = 1'b0;
                    sb_check("false start");
                end
                K_TIMEOUT: begin
                    wait_led(1'b0, ri);
                    step(36);
                    check("carry before", time_bcd, 8'h09);
                    step(4);
                    check("carry after", time_bcd, 8'h10);
                    step(352);
                    check("pre-timeout time_bcd", time_bcd, 8'h98);
                    check("pre-timeout led",      led,      1);
                    sb_q.push_back('{8'h99, tbl[i].exp_best, 1'b0, 1'b0});
                    step(4);
                    sb_check("timeout");
                end
                K_SIMUL: begin
                    step(delay_ms * TICK_DIV - 1);
                    check("pre-expiry led", led, 0);
                    react = 1'b1;
                    sb_q.push_back('{8'h99, tbl[i].exp_best, 1'b1, 1'b0});
                    step(1);
                    react = 1'b0;
                    sb_check("react on expiry");
                end
                default: ;
            endcase
            finish_round(tbl[i], ri);
        end

        start_game();
        wait_led(1'b0, 0);
        step(5);
        Reset = 1'b1;
        #1;
        check("midreset led",       led,       0);
        check("midreset busy",      busy,      0);
        check("midreset time_bcd",  time_bcd,  8'h00);
        check("midreset best_bcd",  best_bcd,  8'h99);
        check("midreset round_idx", round_idx, 0);
        check("midreset done",      done,      0);
        step(2);
        Reset = 1'b0;
        step(2);
        check("post-reset busy", busy, 0);
        check("post-reset led",  led,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
